// File: rtl/anton_neopixel_stream_ctrl_pkg.sv
// Shared types and defaults for the neopixel stream sequencer:
// FSM state encoding, 50 MHz timing defaults and a width helper.
package anton_neopixel_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BIT  = 2'd2,
    ST_GAP  = 2'd3
  } fsm_e;

  localparam int unsigned BUFFER_END_DEFAULT = 255;
  localparam int unsigned T0H_DEFAULT        = 20;
  localparam int unsigned T1H_DEFAULT        = 40;
  localparam int unsigned TBIT_DEFAULT       = 62;
  localparam int unsigned TRESET_DEFAULT     = 2500;

  // Bits needed to hold 0..v-1, never less than 1.
  function automatic int unsigned clog2w(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_ctrl_bit_encoder.sv
// Per-bit timing: bit-cycle counter, high-time compare and registered output.
// Output polarity is inverted when ANTON_NEOPIXEL_INVERT_OUT_EN is defined.
module anton_neopixel_bit_encoder
  import anton_neopixel_stream_ctrl_pkg::*;
#(
  parameter int unsigned T0H  = T0H_DEFAULT,
  parameter int unsigned T1H  = T1H_DEFAULT,
  parameter int unsigned TBIT = TBIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic active_next,
  input  logic bit_next,
  output logic neo_data,
  output logic bit_done
);

  localparam int unsigned CW = clog2w(TBIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);

`ifdef ANTON_NEOPIXEL_INVERT_OUT_EN
  localparam logic NEO_IDLE = 1'b1;
`else
  localparam logic NEO_IDLE = 1'b0;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic          neo_q, neo_d;

  assign bit_done = active && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (active && !bit_done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output is computed from next-cycle state so the register lines up with the FSM.
  always_comb begin
    neo_d = NEO_IDLE ^ (active_next && (cnt_d < (bit_next ? T1H_C : T0H_C)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      neo_q <= NEO_IDLE;
    end else begin
      cnt_q <= cnt_d;
      neo_q <= neo_d;
    end
  end

  assign neo_data = neo_q;

endmodule

// File: rtl/anton_neopixel_stream_ctrl.sv
// Streams the pixel buffer out as a WS2812-style single-wire waveform and
// pulses streamSyncOf at frame end. Option macro: ANTON_NEOPIXEL_INVERT_OUT_EN.
module anton_neopixel_stream_ctrl
  import anton_neopixel_stream_ctrl_pkg::*;
#(
  parameter int unsigned BUFFER_END = BUFFER_END_DEFAULT,
  parameter int unsigned T0H        = T0H_DEFAULT,
  parameter int unsigned T1H        = T1H_DEFAULT,
  parameter int unsigned TBIT       = TBIT_DEFAULT,
  parameter int unsigned TRESET     = TRESET_DEFAULT
) (
  input  logic                              busClk,
  input  logic                              busReset,
  input  logic                              regCtrlRun,
  input  logic                              regCtrlLimit,
  input  logic                              regCtrl32bit,
  input  logic [12:0]                       regMax,
  output logic [clog2w(BUFFER_END+1)-1:0]   pixelAddr,
  input  logic [7:0]                        pixelData,
  output logic                              neoData,
  output logic                              streamSyncOf,
  output logic                              state
);

  localparam int unsigned AW = clog2w(BUFFER_END + 1);
  localparam int unsigned GW = clog2w(TRESET + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TRESET - 1);

  if (!((T0H < T1H) && (T1H < TBIT) && (TRESET > 0))) begin : g_bad_params
    $error("anton_neopixel_stream_ctrl: need T0H < T1H < TBIT and TRESET > 0");
  end

  fsm_e          fsm_q, fsm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;
  logic          m32_q, m32_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          state_q, state_d;
  logic          sync_q, sync_d;

  logic [AW-1:0] end_sel;
  logic [AW:0]   next_idx;
  logic          bit_done;

  always_comb begin
    end_sel = AW'(BUFFER_END);
    if (regCtrlLimit && (32'(regMax) < BUFFER_END)) begin
      end_sel = AW'(regMax);
    end
  end

  // One extra bit so the step past BUFFER_END is visible to the end compare.
  always_comb begin
    next_idx = {1'b0, addr_q} + 1'b1;
    if (m32_q && (next_idx[1:0] == 2'b11)) begin
      next_idx = next_idx + 1'b1;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    addr_d   = addr_q;
    end_d    = end_q;
    m32_d    = m32_q;
    shift_d  = shift_q;
    bitidx_d = bitidx_q;
    gap_d    = gap_q;
    state_d  = state_q;
    sync_d   = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (regCtrlRun && !sync_q) begin
          end_d   = end_sel;
          m32_d   = regCtrl32bit;
          addr_d  = '0;
          state_d = 1'b1;
          fsm_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d  = pixelData;
        bitidx_d = 3'd7;
        fsm_d    = ST_BIT;
      end
      ST_BIT: begin
        if (bit_done) begin
          if (bitidx_q != 3'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            bitidx_d = bitidx_q - 3'd1;
          end else if (next_idx > {1'b0, end_q}) begin
            gap_d = '0;
            fsm_d = ST_GAP;
          end else begin
            addr_d = next_idx[AW-1:0];
            fsm_d  = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          sync_d  = 1'b1;
          state_d = 1'b0;
          fsm_d   = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge busClk) begin
    if (busReset) begin
      fsm_q    <= ST_IDLE;
      addr_q   <= '0;
      end_q    <= '0;
      m32_q    <= 1'b0;
      shift_q  <= '0;
      bitidx_q <= '0;
      gap_q    <= '0;
      state_q  <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      addr_q   <= addr_d;
      end_q    <= end_d;
      m32_q    <= m32_d;
      shift_q  <= shift_d;
      bitidx_q <= bitidx_d;
      gap_q    <= gap_d;
      state_q  <= state_d;
      sync_q   <= sync_d;
    end
  end

  anton_neopixel_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_encoder (
    .clk         (busClk),
    .rst         (busReset),
    .active      (fsm_q == ST_BIT),
    .active_next (fsm_d == ST_BIT),
    .bit_next    (shift_d[7]),
    .neo_data    (neoData),
    .bit_done    (bit_done)
  );

  assign pixelAddr    = addr_q;
  assign streamSyncOf = sync_q;
  assign state        = state_q;

endmodule
